// File: rtl/cmp1_chk_pkg.sv
// Shared types and helpers for the comparator response checkers.
// Holds the checker FSM encoding, the vector width and the expected-result function.
package cmp1_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int VEC_W = 3;

    function automatic logic exp_c(input logic a, input logic b);
        return ~(a ^ b);
    endfunction

endpackage

// File: rtl/cmp1_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module cmp1_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cmp1_resp_checker.sv
// Response checker for the 1-bit equality comparator: counts vectors and mismatches, reports a pass verdict.
// Optional macro CMP1_CHK_HIST_EN adds a 4-deep history of mismatching {a,b,c} triples on port hist.
module cmp1_resp_checker
    import cmp1_chk_pkg::*;
#(
    parameter int NUM_VEC = 6,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [VEC_W-1:0] first_err_vec
`ifdef CMP1_CHK_HIST_EN
    ,
    output logic [4*VEC_W-1:0] hist
`endif
);

    state_e           state_d, state_q;
    logic             in_ready_d, in_ready_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             pass_d, pass_q;
    logic [CNT_W-1:0] first_err_idx_d, first_err_idx_q;
    logic [VEC_W-1:0] first_err_vec_d, first_err_vec_q;

    logic accept;
    logic mismatch;
    logic clr;
    logic last_vec;

    // in_ready_q is high exactly while in RUN, so it doubles as the accept qualifier.
    assign accept   = in_valid && in_ready_q;
    assign mismatch = (c !== exp_c(a, b));
    assign clr      = start && (state_q != RUN);
    assign last_vec = (vec_cnt == CNT_W'(NUM_VEC - 1));

    cmp1_sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (accept),
        .cnt (vec_cnt)
    );

    cmp1_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (accept && mismatch),
        .cnt (err_cnt)
    );

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            RUN: begin
                if (accept && last_vec) begin
                    state_d    = DONE;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    // The final vector's own mismatch is folded in before the verdict.
                    pass_d     = (err_cnt == '0) && !mismatch;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                pass_d     = 1'b0;
            end
        endcase
    end

    // err_cnt saturates and never wraps to zero, so zero means no mismatch captured yet.
    always_comb begin
        first_err_idx_d = first_err_idx_q;
        first_err_vec_d = first_err_vec_q;
        if (clr) begin
            first_err_idx_d = '0;
            first_err_vec_d = '0;
        end else if (accept && mismatch && (err_cnt == '0)) begin
            first_err_idx_d = vec_cnt;
            first_err_vec_d = {a, b, c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            in_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            first_err_idx_q <= '0;
            first_err_vec_q <= '0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_vec_q <= first_err_vec_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_vec = first_err_vec_q;

`ifdef CMP1_CHK_HIST_EN
    logic [4*VEC_W-1:0] hist_d, hist_q;

    always_comb begin
        hist_d = hist_q;
        if (clr) begin
            hist_d = '0;
        end else if (accept && mismatch) begin
            hist_d = {hist_q[3*VEC_W-1:0], a, b, c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign hist = hist_q;
`endif

endmodule

// File: tb/tb_cmp1_resp_checker.sv
// Self-checking bench for cmp1_resp_checker: vector tables, corner sequences and a random run vs a queue model.
// Exercises the hist port as well when CMP1_CHK_HIST_EN is defined.
module tb_cmp1_resp_checker;

    localparam int NUM_VEC = 6;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst;
    logic start, in_valid, a, b, c;
    logic in_ready, busy, done, pass;
    logic [CNT_W-1:0] vec_cnt, err_cnt, first_err_idx;
    logic [2:0] first_err_vec;

    logic s_start, s_valid, s_a, s_b, s_c;
    logic s_in_ready, s_busy, s_done, s_pass;
    logic [1:0] s_vec_cnt, s_err_cnt, s_first_err_idx;
    logic [2:0] s_first_err_vec;

`ifdef CMP1_CHK_HIST_EN
    logic [11:0] hist, s_hist;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cmp1_resp_checker #(.NUM_VEC(NUM_VEC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .in_ready(in_ready), .busy(busy),
        .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .first_err_vec(first_err_vec)
`ifdef CMP1_CHK_HIST_EN
        , .hist(hist)
`endif
    );

    cmp1_resp_checker #(.NUM_VEC(3), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid),
        .a(s_a), .b(s_b), .c(s_c), .in_ready(s_in_ready), .busy(s_busy),
        .done(s_done), .pass(s_pass), .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt),
        .first_err_idx(s_first_err_idx), .first_err_vec(s_first_err_vec)
`ifdef CMP1_CHK_HIST_EN
        , .hist(s_hist)
`endif
    );

    typedef struct packed {
        bit         st;
        bit         v;
        bit         a;
        bit         b;
        bit         c;
        logic [7:0] ev;
        logic [7:0] ee;
        bit         ed;
        bit         ep;
    } vec_row_t;

    function automatic vec_row_t row(bit st, bit v, bit ai, bit bi, bit ci,
                                     int ev, int ee, bit ed, bit ep);
        vec_row_t r;
        r.st = st; r.v = v; r.a = ai; r.b = bi; r.c = ci;
        r.ev = 8'(ev); r.ee = 8'(ee); r.ed = ed; r.ep = ep;
        return r;
    endfunction

    // Reference model: the accepted vectors of the current run, plus run/done flags.
    bit         m_run, m_done;
    logic [2:0] m_q[$];

    function automatic void m_reset();
        m_q.delete();
        m_run  = 1'b0;
        m_done = 1'b0;
    endfunction

    function automatic void m_edge(bit st, bit v, bit ai, bit bi, bit ci);
        if (!m_run) begin
            if (st) begin
                m_q.delete();
                m_run  = 1'b1;
                m_done = 1'b0;
            end
        end else if (v) begin
            m_q.push_back({ai, bi, ci});
            if (m_q.size() == NUM_VEC) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        int         errs;
        int         fidx;
        logic [2:0] fvec;
        bit         found;
        logic [11:0] h;
        errs = 0; fidx = 0; fvec = 3'b000; found = 1'b0; h = '0;
        foreach (m_q[i]) begin
            // A vector is good when c reports whether a and b are equal.
            if (m_q[i][0] != (m_q[i][2] == m_q[i][1])) begin
                errs++;
                h = {h[8:0], m_q[i]};
                if (!found) begin
                    found = 1'b1;
                    fidx  = i;
                    fvec  = m_q[i];
                end
            end
        end
        if (errs > 255) errs = 255;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(m_run));
        check({tag, ".busy"}, 32'(busy), 32'(m_run));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".pass"}, 32'(pass), 32'(m_done && errs == 0));
        check({tag, ".vec_cnt"}, 32'(vec_cnt), 32'(m_q.size()));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(errs));
        check({tag, ".first_err_idx"}, 32'(first_err_idx), 32'(fidx));
        check({tag, ".first_err_vec"}, 32'(first_err_vec), 32'(fvec));
`ifdef CMP1_CHK_HIST_EN
        check({tag, ".hist"}, 32'(hist), 32'(h));
`endif
    endtask

    task automatic step(input bit st, input bit v, input bit ai, input bit bi, input bit ci,
                        input string tag);
        start = st; in_valid = v; a = ai; b = bi; c = ci;
        @(posedge clk);
        #1;
        m_edge(st, v, ai, bi, ci);
        compare_all(tag);
    endtask

    task automatic run_table(input vec_row_t tbl[7], input string tag);
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, $sformatf("%s[%0d]", tag, i));
            check($sformatf("%s[%0d].tab_vec", tag, i), 32'(vec_cnt), 32'(tbl[i].ev));
            check($sformatf("%s[%0d].tab_err", tag, i), 32'(err_cnt), 32'(tbl[i].ee));
            check($sformatf("%s[%0d].tab_done", tag, i), 32'(done), 32'(tbl[i].ed));
            check($sformatf("%s[%0d].tab_pass", tag, i), 32'(pass), 32'(tbl[i].ep));
        end
    endtask

    vec_row_t run1[7];
    vec_row_t run2[7];

    initial begin
        bit ra, rb, rc;

        run1[0] = row(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run1[1] = row(0, 1, 0, 0, 1, 1, 0, 0, 0);
        run1[2] = row(0, 1, 0, 1, 0, 2, 0, 0, 0);
        run1[3] = row(0, 1, 1, 0, 0, 3, 0, 0, 0);
        run1[4] = row(0, 1, 1, 1, 1, 4, 0, 0, 0);
        run1[5] = row(0, 1, 0, 0, 1, 5, 0, 0, 0);
        run1[6] = row(0, 1, 0, 1, 0, 6, 0, 1, 1);
        run2    = run1;
        run2[3] = row(0, 1, 1, 0, 1, 3, 1, 0, 0);
        run2[4] = row(0, 1, 1, 1, 1, 4, 1, 0, 0);
        run2[5] = row(0, 1, 0, 0, 1, 5, 1, 0, 0);
        run2[6] = row(0, 1, 0, 1, 0, 6, 1, 1, 0);

        rst = 1'b1;
        start = 0; in_valid = 0; a = 0; b = 0; c = 0;
        s_start = 0; s_valid = 0; s_a = 0; s_b = 0; s_c = 0;
        m_reset();
        #12;
        compare_all("reset");
        rst = 1'b0;

        // IDLE ignores in_valid.
        step(0, 1, 0, 0, 1, "idle_valid0");
        step(0, 1, 1, 1, 0, "idle_valid1");

        run_table(run1, "run1");
        run_table(run2, "run2");
        check("run2.first_err_idx", 32'(first_err_idx), 32'd2);
        check("run2.first_err_vec", 32'(first_err_vec), 32'b101);

        // Gapped run with mismatches at vectors 1 and 4.
        step(1, 0, 0, 0, 0, "gap_start");
        for (int i = 0; i < NUM_VEC; i++) begin
            bit bad;
            bad = (i == 1) || (i == 4);
            step(0, 1, i[0], i[1], (i[0] == i[1]) ^ bad, $sformatf("gap_v%0d", i));
            if (i < NUM_VEC - 1) begin
                step(0, 0, 1, 0, 1, $sformatf("gap_idle%0d", i));
                check($sformatf("gap_idle%0d.not_done", i), 32'(done), 32'd0);
            end
        end
        check("gap.done", 32'(done), 32'd1);
        check("gap.err_cnt", 32'(err_cnt), 32'd2);
        check("gap.first_err_idx", 32'(first_err_idx), 32'd1);
        check("gap.vec_cnt", 32'(vec_cnt), 32'd6);

        // DONE ignores in_valid.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, $sformatf("done_valid%0d", i));
        check("done_valid.vec_cnt", 32'(vec_cnt), 32'd6);

        // start in DONE restarts; start held through RUN is ignored.
        step(1, 0, 0, 0, 0, "restart");
        check("restart.vec_cnt", 32'(vec_cnt), 32'd0);
        check("restart.busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, $sformatf("held_start%0d", i));
        check("held_start.vec_cnt", 32'(vec_cnt), 32'd3);

        // Asynchronous reset mid-run.
        start = 0; in_valid = 0;
        rst = 1'b1;
        #1;
        m_reset();
        compare_all("async_rst");
        check("async_rst.vec_cnt", 32'(vec_cnt), 32'd0);
        #2;
        rst = 1'b0;
        step(0, 1, 0, 0, 1, "post_rst_idle");
        run_table(run1, "run_after_rst");

        // Narrow instance: every vector mismatches.
        s_start = 1;
        step(0, 0, 0, 0, 0, "s_start");
        s_start = 0; s_valid = 1; s_a = 0; s_b = 0; s_c = 0;
        step(0, 0, 0, 0, 0, "s_v0");
        s_a = 0; s_b = 1; s_c = 1;
        step(0, 0, 0, 0, 0, "s_v1");
        check("small.not_done", 32'(s_done), 32'd0);
        s_a = 1; s_b = 1; s_c = 0;
        step(0, 0, 0, 0, 0, "s_v2");
        s_valid = 0;
        check("small.done", 32'(s_done), 32'd1);
        check("small.pass", 32'(s_pass), 32'd0);
        check("small.err_cnt", 32'(s_err_cnt), 32'd3);
        check("small.vec_cnt", 32'(s_vec_cnt), 32'd3);
        check("small.first_err_idx", 32'(s_first_err_idx), 32'd0);
        check("small.first_err_vec", 32'(s_first_err_vec), 32'b000);
`ifdef CMP1_CHK_HIST_EN
        check("small.hist", 32'(s_hist), 32'b000_000_011_110);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : (ra == rb);
            step($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), ra, rb, rc,
                 $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
